// File: rtl/rst_pulse_gen_pkg.sv
// Shared reset-driver types, cause codes and default timing.
// CONFIG_FOR_SIM selects short timings for fast simulation builds.
package rst_pkg;

    typedef enum logic [1:0] {
        POR     = 2'd0,
        IDLE    = 2'd1,
        ASSERT  = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_BTN = 2'b01;
    localparam logic [1:0] CAUSE_WDT = 2'b10;

    localparam int unsigned DEF_CNT_W = 16;

`ifdef CONFIG_FOR_SIM
    localparam int unsigned DEF_POR_CYC      = 4;
    localparam int unsigned DEF_ASSERT_CYC   = 5;
    localparam int unsigned DEF_HOLDOFF_CYC  = 8;
    localparam int unsigned DEF_WDT_CYC      = 10;
    localparam int unsigned DEF_DEBOUNCE_CYC = 3;
`else
    // 32.768 kHz: 3277 ~ 100 ms, 16384 ~ 500 ms, 655 ~ 20 ms
    localparam int unsigned DEF_POR_CYC      = 3277;
    localparam int unsigned DEF_ASSERT_CYC   = 3277;
    localparam int unsigned DEF_HOLDOFF_CYC  = 16384;
    localparam int unsigned DEF_WDT_CYC      = 32768;
    localparam int unsigned DEF_DEBOUNCE_CYC = 655;
`endif

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rst_pulse_gen_if.sv
// Button request in, platform reset and status out.
// Watchdog controls exist only when RST_PULSE_WDT_EN is defined.
interface rst_pulse_gen_if;

    logic       i_req;
    logic       o_rst_out_n;
    logic       o_busy;
    logic [1:0] o_cause;
    logic [7:0] o_rst_cnt;
`ifdef RST_PULSE_WDT_EN
    logic       i_wdt_en;
    logic       i_wdt_kick;

    modport master (
        output i_req, i_wdt_en, i_wdt_kick,
        input  o_rst_out_n, o_busy, o_cause, o_rst_cnt
    );
    modport slave (
        input  i_req, i_wdt_en, i_wdt_kick,
        output o_rst_out_n, o_busy, o_cause, o_rst_cnt
    );
`else
    modport master (
        output i_req,
        input  o_rst_out_n, o_busy, o_cause, o_rst_cnt
    );
    modport slave (
        input  i_req,
        output o_rst_out_n, o_busy, o_cause, o_rst_cnt
    );
`endif

endinterface

// File: rtl/rst_pulse_gen_edge.sv
// Registered rising-edge detector with selectable reset level.
// Resetting to 1 suppresses a rise for a level held through reset.
module rst_edge_det #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_rise
);

    logic r_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_d <= RST_VAL;
        else          r_d <= i_d;
    end

    assign o_rise = i_d & ~r_d;

endmodule

// File: rtl/rst_pulse_gen.sv
// Board-reset driver: POR pulse, button pulse with holdoff, cause/count.
// RST_PULSE_WDT_EN adds an IDLE-only watchdog that can trigger a pulse.
module rst_pulse_gen
    import rst_pkg::*;
#(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned POR_CYC    = DEF_POR_CYC,
    parameter int unsigned ASSERT_CYC = DEF_ASSERT_CYC,
`ifdef RST_PULSE_WDT_EN
    parameter int unsigned HOLDOFF_CYC = DEF_HOLDOFF_CYC,
    parameter int unsigned WDT_CYC     = DEF_WDT_CYC
`else
    parameter int unsigned HOLDOFF_CYC = DEF_HOLDOFF_CYC
`endif
) (
    input  logic           i_clk_32k,
    input  logic           i_rst_n,
    rst_pulse_gen_if.slave bus
);

    localparam logic [CNT_W-1:0] POR_END = CNT_W'(POR_CYC - 1);
    localparam logic [CNT_W-1:0] AST_END = CNT_W'(ASSERT_CYC - 1);
    localparam logic [CNT_W-1:0] HLD_END = CNT_W'(HOLDOFF_CYC - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rst_out_n;
    logic             r_busy;
    logic [1:0]       r_cause;
    logic [7:0]       r_rst_cnt;
    logic             w_rise;
    logic             w_wdt_to;

    rst_edge_det #(
        .RST_VAL (1'b1)
    ) u_req_edge (
        .i_clk   (i_clk_32k),
        .i_rst_n (i_rst_n),
        .i_d     (bus.i_req),
        .o_rise  (w_rise)
    );

`ifdef RST_PULSE_WDT_EN
    localparam logic [CNT_W:0] WDT_END = (CNT_W+1)'(WDT_CYC - 1);

    logic [CNT_W:0] r_wdt;
    logic           w_wdt_run;

    // A kick in the timeout cycle masks the timeout
    assign w_wdt_run = (r_state == IDLE) & bus.i_wdt_en
                     & ~bus.i_wdt_kick;
    assign w_wdt_to  = w_wdt_run & (r_wdt == WDT_END);

    always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
        if (!i_rst_n)
            r_wdt <= '0;
        else if (!w_wdt_run || w_wdt_to || w_rise)
            r_wdt <= '0;
        else
            r_wdt <= r_wdt + (CNT_W+1)'(1);
    end
`else
    assign w_wdt_to = 1'b0;
`endif

    always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= POR;
            r_cnt       <= '0;
            r_rst_out_n <= 1'b0;
            r_busy      <= 1'b1;
            r_cause     <= CAUSE_POR;
            r_rst_cnt   <= 8'd0;
        end else begin
            unique case (r_state)
                POR: begin
                    if (r_cnt == POR_END) begin
                        r_state     <= IDLE;
                        r_cnt       <= '0;
                        r_rst_out_n <= 1'b1;
                        r_busy      <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                IDLE: begin
                    // Button rise has priority over watchdog
                    if (w_rise || w_wdt_to) begin
                        r_state     <= ASSERT;
                        r_cnt       <= '0;
                        r_rst_out_n <= 1'b0;
                        r_busy      <= 1'b1;
                        r_cause     <= w_rise ? CAUSE_BTN : CAUSE_WDT;
                        r_rst_cnt   <= sat_inc8(r_rst_cnt);
                    end
                end
                ASSERT: begin
                    if (r_cnt == AST_END) begin
                        r_state     <= HOLDOFF;
                        r_cnt       <= '0;
                        r_rst_out_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                HOLDOFF: begin
                    if (r_cnt == HLD_END) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign bus.o_rst_out_n = r_rst_out_n;
    assign bus.o_busy      = r_busy;
    assign bus.o_cause     = r_cause;
    assign bus.o_rst_cnt   = r_rst_cnt;

endmodule

// File: tb/tb_rst_pulse_gen.sv
// Randomized bench for rst_pulse_gen against a countdown model.
// Build with RST_PULSE_WDT_EN to also exercise the watchdog.
module tb_rst_pulse_gen;

    localparam int POR   = 4;
    localparam int AST   = 5;
    localparam int HLD   = 8;
    localparam int WDT   = 10;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    rst_pulse_gen_if bus ();

    rst_pulse_gen #(
        .CNT_W       (16),
        .POR_CYC     (POR),
        .ASSERT_CYC  (AST),
`ifdef RST_PULSE_WDT_EN
        .HOLDOFF_CYC (HLD),
        .WDT_CYC     (WDT)
`else
        .HOLDOFF_CYC (HLD)
`endif
    ) dut (
        .i_clk_32k (clk),
        .i_rst_n   (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: remaining low / busy cycles of the current pulse
    int   m_low;
    int   m_busy;
    int   m_cause;
    int   m_cnt;
    logic m_prev;
    int   m_wd;
    logic m_en;
    logic m_kick;

`ifdef RST_PULSE_WDT_EN
    assign m_en   = bus.i_wdt_en;
    assign m_kick = bus.i_wdt_kick;
`else
    assign m_en   = 1'b0;
    assign m_kick = 1'b0;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_low   <= POR;
            m_busy  <= POR;
            m_cause <= 0;
            m_cnt   <= 0;
            m_prev  <= 1'b1;
            m_wd    <= 0;
        end else begin
            m_prev <= bus.i_req;
            if (m_busy != 0) begin
                m_busy <= m_busy - 1;
                if (m_low != 0) m_low <= m_low - 1;
                m_wd <= 0;
            end else if ((bus.i_req && !m_prev) ||
                         (m_en && !m_kick && m_wd == WDT - 1)) begin
                m_low   <= AST;
                m_busy  <= AST + HLD;
                m_cause <= (bus.i_req && !m_prev) ? 1 : 2;
                m_cnt   <= (m_cnt == 255) ? 255 : m_cnt + 1;
                m_wd    <= 0;
            end else begin
                m_wd <= (m_en && !m_kick) ? m_wd + 1 : 0;
            end
        end
    end

    task automatic chk(input string nm, input int act,
                       input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("rst_out_n", int'(bus.o_rst_out_n),
                (m_low == 0) ? 1 : 0);
            chk("busy", int'(bus.o_busy), (m_busy != 0) ? 1 : 0);
            chk("cause", int'(bus.o_cause), m_cause);
            chk("rst_cnt", int'(bus.o_rst_cnt), m_cnt);
            @(negedge clk);
        end
    endtask

    task automatic press();
        bus.i_req = 1'b0;
        tick(1);
        bus.i_req = 1'b1;
        tick(1);
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.i_req = 1'b1;
`ifdef RST_PULSE_WDT_EN
        bus.i_wdt_en   = 1'b0;
        bus.i_wdt_kick = 1'b0;
`endif
        tick(3);
        chk("reset_rst_out_n", int'(bus.o_rst_out_n), 0);
        chk("reset_busy", int'(bus.o_busy), 1);
        chk("reset_cause", int'(bus.o_cause), 0);
        chk("reset_cnt", int'(bus.o_rst_cnt), 0);

        // POR: low for exactly 4 edges, held button ignored
        rst_n = 1'b1;
        tick(3);
        chk("por_low_c3", int'(bus.o_rst_out_n), 0);
        tick(1);
        chk("por_high_c4", int'(bus.o_rst_out_n), 1);
        chk("por_busy_c4", int'(bus.o_busy), 0);
        tick(20);
        chk("held_no_pulse", int'(bus.o_rst_cnt), 0);

        // Button pulse
        press();
        chk("btn_low", int'(bus.o_rst_out_n), 0);
        chk("btn_cause", int'(bus.o_cause), 1);
        chk("btn_cnt", int'(bus.o_rst_cnt), 1);
        tick(4);
        chk("btn_low_c5", int'(bus.o_rst_out_n), 0);
        tick(1);
        chk("btn_high_c6", int'(bus.o_rst_out_n), 1);
        tick(7);
        chk("btn_busy_c13", int'(bus.o_busy), 1);
        tick(1);
        chk("btn_idle_c14", int'(bus.o_busy), 0);
        tick(20);
        chk("btn_held", int'(bus.o_rst_cnt), 1);

        // Toggle during holdoff incl. a rise on its last cycle
        press();
        for (int i = 0; i < 10; i++) begin
            bus.i_req = ~bus.i_req;
            tick(1);
        end
        bus.i_req = 1'b0;
        tick(1);
        bus.i_req = 1'b1;
        tick(1);
        tick(10);
        chk("holdoff_ignore", int'(bus.o_rst_cnt), 2);

        // Random button activity
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) bus.i_req = ~bus.i_req;
            tick(1);
        end

        // Saturation
        bus.i_req = 1'b0;
        tick(14);
        for (int i = 0; i < 300; i++) begin
            press();
            bus.i_req = 1'b0;
            tick(13);
        end
        chk("sat_cnt", int'(bus.o_rst_cnt), 255);

        // Async reset in ASSERT cycle 2
        press();
        tick(1);
        rst_n = 1'b0;
        #1;
        chk("arst_rst_out_n", int'(bus.o_rst_out_n), 0);
        chk("arst_busy", int'(bus.o_busy), 1);
        chk("arst_cause", int'(bus.o_cause), 0);
        chk("arst_cnt", int'(bus.o_rst_cnt), 0);
        @(negedge clk);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("arst_por_low", int'(bus.o_rst_out_n), 0);
        tick(1);
        chk("arst_por_high", int'(bus.o_rst_out_n), 1);
        chk("arst_cnt_zero", int'(bus.o_rst_cnt), 0);

`ifdef RST_PULSE_WDT_EN
        bus.i_req = 1'b0;
        tick(20);
        bus.i_wdt_en = 1'b1;
        tick(9);
        chk("wdt_before", int'(bus.o_rst_out_n), 1);
        tick(1);
        chk("wdt_low", int'(bus.o_rst_out_n), 0);
        chk("wdt_cause", int'(bus.o_cause), 2);
        tick(14);
        for (int i = 0; i < 6; i++) begin
            tick(7);
            bus.i_wdt_kick = 1'b1;
            tick(1);
            bus.i_wdt_kick = 1'b0;
        end
        chk("wdt_kicked", int'(bus.o_busy), 0);
        bus.i_wdt_en = 1'b0;
        tick(1);
        bus.i_wdt_en = 1'b1;
        tick(9);
        bus.i_req = 1'b1;
        tick(1);
        chk("wdt_btn_wins", int'(bus.o_cause), 1);
        bus.i_wdt_en = 1'b0;
        tick(14);
        chk("wdt_single", int'(bus.o_busy), 0);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) bus.i_req = ~bus.i_req;
            bus.i_wdt_en   = ($urandom_range(0, 9) != 0);
            bus.i_wdt_kick = ($urandom_range(0, 12) == 0);
            tick(1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
